// File: rtl/systolic_mac_engine.sv
// N x N output-stationary systolic MAC array computing C = A * B over k_len beats.
// Optional build macro SYSTOLIC_SATURATE_EN: accumulators clamp on overflow instead of wrapping.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; results of the previous job remain on c_out
// LOAD   | accepting a_col/b_row beats until k_len beats have been taken
// DRAIN  | 2N-1 cycles flushing zeros so the last beat reaches PE(N-1,N-1)
// DONE   | c_out valid and frozen until out_valid & out_ready
module systolic_mac_engine #(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int ACC_W = 40,
    parameter int K_MAX = 256,
    localparam int K_W  = $clog2(K_MAX + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*W-1:0]         a_col,
    input  logic [N*W-1:0]         b_row,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*N*ACC_W-1:0]   c_out,
    output logic                   overflow
);

    localparam int DW = $clog2(2 * N);
    localparam int SK = N * (N - 1) / 2;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nx;
    logic [K_W-1:0]  beats_left;
    logic [DW-1:0]   drain_cnt;
    logic            clr, adv, beat;

    logic signed [W-1:0]       a_inj  [N];
    logic signed [W-1:0]       b_inj  [N];
    logic signed [W-1:0]       a_edge [N];
    logic signed [W-1:0]       b_edge [N];
    logic signed [W-1:0]       a_sk   [SK];
    logic signed [W-1:0]       b_sk   [SK];
    logic signed [W-1:0]       a_pipe [N][N-1];
    logic signed [W-1:0]       b_pipe [N-1][N];
    logic signed [W-1:0]       a_l    [N][N];
    logic signed [W-1:0]       b_t    [N][N];
    logic signed [2*W-1:0]     prod   [N][N];
    logic signed [ACC_W:0]     sum    [N][N];
    logic signed [ACC_W-1:0]   acc    [N][N];
    logic signed [ACC_W-1:0]   acc_nx [N][N];
    logic                      ovf_any;

    assign clr  = (state == S_IDLE) && start;
    assign adv  = (state == S_LOAD) || (state == S_DRAIN);
    assign beat = (state == S_LOAD) && in_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = (k_len == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && beats_left == K_W'(1)) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == '0) state_nx = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // drain_cnt is preloaded throughout LOAD so DRAIN always starts at 2N-2
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beats_left <= '0;
            drain_cnt  <= '0;
        end else begin
            if (clr) begin
                beats_left <= k_len;
            end else if (beat) begin
                beats_left <= beats_left - K_W'(1);
            end
            if (state == S_LOAD) begin
                drain_cnt <= DW'(2 * N - 2);
            end else if (state == S_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_inj[i] = '0;
            b_inj[i] = '0;
            if (beat) begin
                a_inj[i] = a_col[i*W +: W];
                b_inj[i] = b_row[i*W +: W];
            end
        end
    end

    // Skew lines are packed triangularly: row/column r owns a_sk[r(r-1)/2 +: r]
    always_comb begin
        a_edge[0] = a_inj[0];
        b_edge[0] = b_inj[0];
        for (int r = 1; r < N; r++) begin
            a_edge[r] = a_sk[r*(r-1)/2 + r - 1];
            b_edge[r] = b_sk[r*(r-1)/2 + r - 1];
        end
    end

    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_l[r][0] = a_edge[r];
            for (int c = 1; c < N; c++) a_l[r][c] = a_pipe[r][c-1];
        end
        for (int c = 0; c < N; c++) begin
            b_t[0][c] = b_edge[c];
            for (int r = 1; r < N; r++) b_t[r][c] = b_pipe[r-1][c];
        end
    end

    always_comb begin
        ovf_any = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                prod[r][c]   = a_l[r][c] * b_t[r][c];
                sum[r][c]    = {acc[r][c][ACC_W-1], acc[r][c]}
                             + {{(ACC_W + 1 - 2*W){prod[r][c][2*W-1]}}, prod[r][c]};
                acc_nx[r][c] = sum[r][c][ACC_W-1:0];
                if (sum[r][c][ACC_W] != sum[r][c][ACC_W-1]) begin
                    ovf_any = 1'b1;
`ifdef SYSTOLIC_SATURATE_EN
                    acc_nx[r][c] = sum[r][c][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                    : {1'b0, {(ACC_W-1){1'b1}}};
`endif
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SK; i++) begin
                a_sk[i] <= '0;
                b_sk[i] <= '0;
            end
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    a_pipe[r][c] <= '0;
                    b_pipe[c][r] <= '0;
                end
                for (int c = 0; c < N; c++) acc[r][c] <= '0;
            end
            overflow <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < SK; i++) begin
                a_sk[i] <= '0;
                b_sk[i] <= '0;
            end
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    a_pipe[r][c] <= '0;
                    b_pipe[c][r] <= '0;
                end
                for (int c = 0; c < N; c++) acc[r][c] <= '0;
            end
            overflow <= 1'b0;
        end else if (adv) begin
            for (int r = 1; r < N; r++) begin
                a_sk[r*(r-1)/2] <= a_inj[r];
                b_sk[r*(r-1)/2] <= b_inj[r];
                for (int i = 1; i < r; i++) begin
                    a_sk[r*(r-1)/2 + i] <= a_sk[r*(r-1)/2 + i - 1];
                    b_sk[r*(r-1)/2 + i] <= b_sk[r*(r-1)/2 + i - 1];
                end
            end
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N - 1; c++) begin
                    a_pipe[r][c] <= a_l[r][c];
                    b_pipe[c][r] <= b_t[c][r];
                end
                for (int c = 0; c < N; c++) acc[r][c] <= acc_nx[r][c];
            end
            overflow <= overflow | ovf_any;
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign c_out[(r*N + c)*ACC_W +: ACC_W] = acc[r][c];
        end
    end

endmodule

// File: doc/systolic_mac_engine.md
SYSTOLIC_MAC_ENGINE -- requirements
Module: systolic_mac_engine

Interface
REQ-001 SHALL have parameter N, default 8: array dimension (N x N processing elements).
REQ-002 SHALL have parameter W, default 16: signed operand width.
REQ-003 SHALL have parameter ACC_W, default 40: signed accumulator/result width; ACC_W >= 2*W.
REQ-004 SHALL have parameter K_MAX, default 256: maximum inner dimension; K_W = $clog2(K_MAX+1).
REQ-005 SHALL have port clock, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: request a new product; sampled only in IDLE.
REQ-008 SHALL have port k_len, input, K_W: inner dimension K, latched on accepted start.
REQ-009 SHALL have port in_valid, input, 1: a_col/b_row beat present.
REQ-010 SHALL have port in_ready, output, 1: engine accepts a beat.
REQ-011 SHALL have port a_col, input, N*W: column k of A, element r = A[r][k].
REQ-012 SHALL have port b_row, input, N*W: row k of B, element c = B[k][c].
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port out_valid, output, 1: result matrix valid.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-016 SHALL have port c_out, output, N*N*ACC_W: C[r][c] = sum over k of A[r][k]*B[k][c].
REQ-017 SHALL have port overflow, output, 1: at least one accumulator overflowed in the current job.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE.
REQ-019 IDLE: start=1 SHALL latch k_len, clear all accumulators and overflow, and go to LOAD; if k_len=0, go directly to DONE with all C=0.
REQ-020 LOAD: in_ready SHALL be 1; each cycle with in_valid&in_ready is one beat; after the k_len-th beat, go to DRAIN.
REQ-021 Skew SHALL be internal: A row r delayed r cycles, B column c delayed c cycles; PE(r,c) receives beat k's operands at the same cycle.
REQ-022 The array SHALL advance every cycle in LOAD and DRAIN; a cycle with no beat SHALL inject zeros, so bubbles do not alter results.
REQ-023 Each PE SHALL compute acc <= acc + sign-extended(a*b) at ACC_W bits, and forward a right and b down one register per cycle.
REQ-024 DRAIN SHALL last exactly 2N-1 cycles and accept no beats; then go to DONE.
REQ-025 DONE: out_valid=1 and c_out stable until out_valid&out_ready, then go to IDLE on the next cycle.
REQ-026 start SHALL be ignored outside IDLE; in_valid SHALL be ignored outside LOAD.
REQ-027 Latency: last beat to out_valid SHALL be 2N cycles.
REQ-028 overflow SHALL be sticky per job, set when any signed accumulate result exceeds ACC_W range.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, in_ready=0, busy=0, out_valid=0, overflow=0, c_out=0, and clear all skew and PE registers, including mid-LOAD or mid-DRAIN.
REQ-030 After reset_n deasserts, the first job SHALL behave identically to one after a normal DONE.

Configuration
REQ-031 With macro SYSTOLIC_SATURATE_EN defined, an overflowing accumulator SHALL clamp to max/min signed ACC_W value and hold there while the overflow persists; without it, the accumulator SHALL wrap modulo 2^ACC_W; overflow SHALL be reported in both builds.

Verification
REQ-032 N=4, W=8, ACC_W=24, k_len=4, A=identity, B[k][c]=4k+c -> c_out equals B, out_valid exactly 8 cycles after the last beat, overflow=0.
REQ-033 Same A/B with in_valid low on alternate cycles -> identical c_out; in_ready drops when LOAD ends after the 4th beat.
REQ-034 k_len=0 -> DONE next cycle, all C=0, no beats accepted.
REQ-035 out_ready held low 10 cycles in DONE -> c_out stable, start pulses ignored, IDLE one cycle after handshake.
REQ-036 ACC_W=16, all operands 127, k_len=4 -> overflow=1; C=32767 with SYSTOLIC_SATURATE_EN, C=64516-65536=-1020 without.
REQ-037 reset_n pulsed low after 2 beats of a job -> outputs zero immediately; a fresh job then returns correct results.
